// File: rtl/field_arith_defs.sv
// Field parameters and modular helpers for the Mersenne prime p = 2^61 - 1.
// Operands are assumed to already be reduced into [0, p).
package field_arith_defs;
  localparam int F_NBITS = 61;
  localparam int F1 = F_NBITS + 1;
  localparam int F2 = 2 * F_NBITS;
  localparam logic [F_NBITS-1:0] F_PRIME = {F_NBITS{1'b1}};

  // 2^61 == 1 (mod p): fold the high half onto the low half twice, then subtract p once.
  function automatic logic [F_NBITS-1:0] f_mred(input logic [F2-1:0] x);
    logic [F1-1:0] s, s2, d;
    s  = {1'b0, x[F_NBITS-1:0]} + {1'b0, x[F2-1:F_NBITS]};
    s2 = {1'b0, s[F_NBITS-1:0]} + F1'(s[F_NBITS]);
    d  = s2 - {1'b0, F_PRIME};
    return (s2 >= {1'b0, F_PRIME}) ? d[F_NBITS-1:0] : s2[F_NBITS-1:0];
  endfunction

  function automatic logic [F_NBITS-1:0] f_madd(input logic [F_NBITS-1:0] a,
                                                 input logic [F_NBITS-1:0] b);
    logic [F1-1:0] s, d;
    s = {1'b0, a} + {1'b0, b};
    d = s - {1'b0, F_PRIME};
    return (s >= {1'b0, F_PRIME}) ? d[F_NBITS-1:0] : s[F_NBITS-1:0];
  endfunction
endpackage

// File: rtl/prover_v_update_pkg.sv
// FSM states of the V-table fold sequencer.
package prover_v_update_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_CAPT, ST_COMP, ST_WRITE, ST_DONE
  } v_upd_state_e;
endpackage

// File: rtl/prover_compute_v_elem.sv
// Computes m_tau_p1*v0 + tau*v1 mod p. Operands are sampled the cycle after en;
// ready_pulse/vtau appear 4 cycles after en.
module prover_compute_v_elem
  import field_arith_defs::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] v0,
  input  logic [F_NBITS-1:0] v1,
  input  logic [F_NBITS-1:0] tau,
  input  logic [F_NBITS-1:0] m_tau_p1,
  output logic               ready_pulse,
  output logic [F_NBITS-1:0] vtau
);
  localparam int STAGES = 3;

  logic [STAGES:0]      vld_pipe;
  logic [F2-1:0]        pa_q, pb_q;
  logic [F_NBITS-1:0]   ra_q, rb_q, sum_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      vld_pipe <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      sum_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], en};
      if (vld_pipe[0]) begin
        pa_q <= F2'(m_tau_p1) * F2'(v0);
        pb_q <= F2'(tau) * F2'(v1);
      end
      if (vld_pipe[1]) begin
        ra_q <= f_mred(pa_q);
        rb_q <= f_mred(pb_q);
      end
      if (vld_pipe[2]) sum_q <= f_madd(ra_q, rb_q);
    end
  end

  assign ready_pulse = vld_pipe[STAGES];
  assign vtau        = sum_q;
endmodule

// File: rtl/prover_v_update_ctrl.sv
// Folds the V table in place: V'[j] = (1-tau)*V[2j] + tau*V[2j+1] for j < 2^(len_log-1),
// one pair at a time through a single shared compute element.
module prover_v_update_ctrl
  import field_arith_defs::*;
  import prover_v_update_pkg::*;
#(
  parameter  int MAX_LOG = 10,
  localparam int ALEN    = MAX_LOG,
  localparam int LW      = $clog2(MAX_LOG + 1)
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [LW-1:0]      len_log,
  input  logic [F_NBITS-1:0] tau,
  input  logic [F_NBITS-1:0] m_tau_p1,
  output logic               rd_en,
  output logic [ALEN-1:0]    rd_addr,
  input  logic [F_NBITS-1:0] rd_data0,
  input  logic [F_NBITS-1:0] rd_data1,
  output logic               wr_en,
  output logic [ALEN-1:0]    wr_addr,
  output logic [F_NBITS-1:0] wr_data,
  output logic               ready,
  output logic               ready_pulse
);
  v_upd_state_e         state_q, state_d;
  logic [LW-1:0]        len_q, len_clamp;
  logic [ALEN-1:0]      j_q, j_last;
  logic [F_NBITS-1:0]   tau_q, mtp_q, v0_q, v1_q, res_q;
  logic                 ve_en, ve_ready_pulse;
  logic [F_NBITS-1:0]   ve_vtau;

  assign len_clamp = (len_log > LW'(MAX_LOG)) ? LW'(MAX_LOG) : len_log;
  // Only meaningful once len_q >= 1, which holds whenever WRITE is reachable.
  assign j_last    = (ALEN'(1) << (len_q - LW'(1))) - ALEN'(1);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    rd_en       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    ready       = 1'b0;
    ready_pulse = 1'b0;
    ve_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (en) state_d = (len_clamp == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        rd_en   = 1'b1;
        rd_addr = {j_q[ALEN-2:0], 1'b0};
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        ve_en   = 1'b1;
        state_d = ST_COMP;
      end
      ST_COMP: if (ve_ready_pulse) state_d = ST_WRITE;
      ST_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = j_q;
        wr_data = res_q;
        state_d = (j_q == j_last) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        ready_pulse = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands stay frozen from CAPT until the result is latched in COMP.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      len_q <= '0;
      tau_q <= '0;
      mtp_q <= '0;
      j_q   <= '0;
      v0_q  <= '0;
      v1_q  <= '0;
      res_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (en) begin
          len_q <= len_clamp;
          tau_q <= tau;
          mtp_q <= m_tau_p1;
          j_q   <= '0;
        end
        ST_CAPT: begin
          v0_q <= rd_data0;
          v1_q <= rd_data1;
        end
        ST_COMP:  if (ve_ready_pulse) res_q <= ve_vtau;
        ST_WRITE: if (j_q != j_last) j_q <= j_q + ALEN'(1);
        default: ;
      endcase
    end
  end

  prover_compute_v_elem u_velem (
    .clk         (clk),
    .rstb        (rstb),
    .en          (ve_en),
    .v0          (v0_q),
    .v1          (v1_q),
    .tau         (tau_q),
    .m_tau_p1    (mtp_q),
    .ready_pulse (ve_ready_pulse),
    .vtau        (ve_vtau)
  );
endmodule
